wvfm_lut_ram: RTL and testbench

Parametrised single-clock, true dual-port waveform look-up RAM, successor to the fixed 2-bit × 16K waveform store. It holds the EPD drive-waveform table: the host loader writes the table through port A and the pixel pipeline reads drive codes through port B. Over the previous block it adds:
- generic width and depth
- cross-port write forwarding
- collision reporting
- a hardware fill engine, since an asynchronous reset cannot clear block RAM

---
 rtl/wvfm_lut_ram.sv | 141 ++++++++++++++
 tb/tb_wvfm_lut_ram.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wvfm_lut_ram.sv
// wvfm_lut_ram: single-clock true dual-port waveform look-up RAM.
// Port A is the host loader side and port B the pixel-pipeline side. The block
// adds cross-port write forwarding, same-address write collision reporting and
// a fill engine that clears the array to FILL two entries per cycle.
// Optional feature macro: WVFM_LUT_AUTOCLR_EN (a fill starts automatically
// after every reset; when undefined the block leaves reset idle).
module wvfm_lut_ram #(
  parameter int             DW   = 2,
  parameter int             AW   = 14,
  parameter logic [DW-1:0]  FILL = '0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_done,
  output logic          coll,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  output logic          a_valid,
  input  logic          b_en,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic [DW-1:0] b_dout,
  output logic          b_valid
);

  localparam int PW = AW - 1;

  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr;
  logic          fill_last;
  logic          start;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic          a_rd, a_wr, b_rd, b_wr;
  logic          same_addr;
  logic [DW-1:0] a_rd_data, b_rd_data;

`ifdef WVFM_LUT_AUTOCLR_EN
  // Pending auto-clear: armed by reset, consumed by the first IDLE cycle so
  // the fill starts on the first clock after reset release.
  logic auto_pend;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                auto_pend <= 1'b1;
    else if (state == S_IDLE) auto_pend <= 1'b0;
  end

  assign start = clr_req | auto_pend;
`else
  assign start = clr_req;
`endif

  // Fill FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Fill FSM next state; clr_req is ignored while a fill is running.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)     state_nxt = S_FILL;
      S_FILL:  if (fill_last) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Fill FSM outputs: busy for the whole fill, clr_done on the last fill write.
  always_comb begin
    busy      = (state == S_FILL);
    fill_last = busy && (ptr == {PW{1'b1}});
    clr_done  = fill_last;
  end

  // Fill pointer; wraps back to zero after the last pair is written.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     ptr <= '0;
    else if (busy) ptr <= ptr + 1'b1;
  end

  assign a_rd      = a_en & ~a_we & ~busy;
  assign a_wr      = a_en &  a_we & ~busy;
  assign b_rd      = b_en & ~b_we & ~busy;
  assign b_wr      = b_en &  b_we & ~busy;
  assign same_addr = (a_addr == b_addr);

  // A read sees the other port's same-cycle write to the same entry.
  assign a_rd_data = (b_wr && same_addr) ? b_din : mem[a_addr];
  assign b_rd_data = (a_wr && same_addr) ? a_din : mem[b_addr];

  // Array writes: fill pairs while busy, else user writes with port A last so
  // it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[{ptr, 1'b0}] <= FILL;
      mem[{ptr, 1'b1}] <= FILL;
    end else begin
      if (b_wr) mem[b_addr] <= b_din;
      if (a_wr) mem[a_addr] <= a_din;
    end
  end

  // Port A read register; dout holds across writes and blocked cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_dout  <= '0;
      a_valid <= 1'b0;
    end else begin
      a_valid <= a_rd;
      if (a_rd) a_dout <= a_rd_data;
    end
  end

  // Port B read register; dout holds across writes and blocked cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_dout  <= '0;
      b_valid <= 1'b0;
    end else begin
      b_valid <= b_rd;
      if (b_rd) b_dout <= b_rd_data;
    end
  end

  // Collision flag: both ports accepted a write to the same entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) coll <= 1'b0;
    else       coll <= a_wr & b_wr & same_addr;
  end

endmodule

// File: tb/tb_wvfm_lut_ram.sv
// Directed testbench for wvfm_lut_ram (DW=2, AW=10, FILL=2'b11).
module tb_wvfm_lut_ram;

  localparam int            DW   = 2;
  localparam int            AW   = 10;
  localparam logic [DW-1:0] FILL = 2'b11;
  localparam int            HALF = 1 << (AW - 1);

  logic          clk = 1'b0;
  logic          rstn;
  logic          clr_req;
  logic          busy, clr_done, coll;
  logic          a_en, a_we, b_en, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din, a_dout, b_dout;
  logic          a_valid, b_valid;

  int checks   = 0;
  int failures = 0;

  wvfm_lut_ram #(.DW(DW), .AW(AW), .FILL(FILL)) dut (
    .clk(clk), .rstn(rstn), .clr_req(clr_req),
    .busy(busy), .clr_done(clr_done), .coll(coll),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_valid(a_valid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout), .b_valid(b_valid)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic en, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_en = en; a_we = we; a_addr = ad; a_din = d;
  endtask

  task automatic drive_b(input logic en, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    b_en = en; b_we = we; b_addr = ad; b_din = d;
  endtask

  task automatic idle;
    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0);
  endtask

  // Steps until busy drops; an expired budget is a failed comparison.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < HALF + 16) begin
      step;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_timeout busy=%b required=0", name, busy);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; clr_req = 1'b0; idle;
    repeat (3) step;
    checks++;
    if ({busy, clr_done, coll, a_valid, b_valid, a_dout, b_dout} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=0",
               {busy, clr_done, coll, a_valid, b_valid, a_dout, b_dout});
    end
    rstn = 1'b1;
    step;
`ifdef WVFM_LUT_AUTOCLR_EN
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_autoclr_busy got=%b required=1", busy); end
    wait_idle("reset_autoclr");
`else
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b required=0", busy); end
`endif
  endtask

  task automatic test_fill;
    int cnt, done_at, done_n, bad;
    clr_req = 1'b1;
    step;
    clr_req = 1'b0;
    cnt = 0; done_at = -1; done_n = 0;
    for (int i = 0; i < HALF + 4; i++) begin
      if (busy) cnt++;
      if (clr_done) begin done_n++; done_at = cnt; end
      // a second request mid-fill must be ignored
      clr_req = (i == 5);
      step;
    end
    clr_req = 1'b0;
    checks++;
    if (cnt != HALF) begin failures++; $display("FAIL fill_busy_cycles got=%0d required=%0d", cnt, HALF); end
    checks++;
    if (done_n != 1 || done_at != HALF) begin
      failures++;
      $display("FAIL fill_clr_done pulses=%0d at_busy_cycle=%0d required=1 at %0d", done_n, done_at, HALF);
    end
    bad = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      drive_a(1'b1, 1'b0, AW'(i), '0);
      step;
      checks++;
      if (a_dout !== FILL || a_valid !== 1'b1) begin
        failures++;
        if (bad < 4) $display("FAIL fill_read addr=%0d got=%b valid=%b required=%b", i, a_dout, a_valid, FILL);
        bad++;
      end
    end
    idle;
    step;
  endtask

  task automatic test_rw;
    drive_a(1'b1, 1'b1, 10'h005, 2'b01);
    step;
    checks++;
    if (a_dout !== FILL || a_valid !== 1'b0) begin
      failures++; $display("FAIL rw_write_nochange a_dout=%b a_valid=%b required=%b 0", a_dout, a_valid, FILL);
    end
    idle;
    drive_b(1'b1, 1'b0, 10'h005, '0);
    step;
    checks++;
    if (b_dout !== 2'b01 || b_valid !== 1'b1) begin
      failures++; $display("FAIL rw_b_read b_dout=%b b_valid=%b required=01 1", b_dout, b_valid);
    end
    idle;
    step;
    checks++;
    if (b_valid !== 1'b0 || b_dout !== 2'b01) begin
      failures++; $display("FAIL rw_valid_pulse b_valid=%b b_dout=%b required=0 01", b_valid, b_dout);
    end
    drive_a(1'b1, 1'b1, 10'h006, 2'b10);
    step;
    drive_a(1'b1, 1'b0, 10'h006, '0);
    step;
    checks++;
    if (a_dout !== 2'b10 || a_valid !== 1'b1) begin
      failures++; $display("FAIL rw_same_port a_dout=%b a_valid=%b required=10 1", a_dout, a_valid);
    end
    idle;
    step;
  endtask

  task automatic test_forward;
    drive_a(1'b1, 1'b1, 10'h3FF, 2'b10);
    drive_b(1'b1, 1'b0, 10'h3FF, '0);
    step;
    checks++;
    if (b_dout !== 2'b10 || b_valid !== 1'b1) begin
      failures++; $display("FAIL fwd_a_to_b b_dout=%b b_valid=%b required=10 1", b_dout, b_valid);
    end
    drive_a(1'b1, 1'b0, 10'h200, '0);
    drive_b(1'b1, 1'b1, 10'h200, 2'b01);
    step;
    checks++;
    if (a_dout !== 2'b01 || a_valid !== 1'b1) begin
      failures++; $display("FAIL fwd_b_to_a a_dout=%b a_valid=%b required=01 1", a_dout, a_valid);
    end
    idle;
    step;
  endtask

  task automatic test_collision;
    drive_a(1'b1, 1'b1, 10'h100, 2'b01);
    drive_b(1'b1, 1'b1, 10'h100, 2'b10);
    step;
    checks++;
    if (coll !== 1'b1) begin failures++; $display("FAIL coll_pulse got=%b required=1", coll); end
    idle;
    step;
    checks++;
    if (coll !== 1'b0) begin failures++; $display("FAIL coll_one_cycle got=%b required=0", coll); end
    drive_a(1'b1, 1'b0, 10'h100, '0);
    step;
    checks++;
    if (a_dout !== 2'b01) begin failures++; $display("FAIL coll_a_wins got=%b required=01", a_dout); end
    drive_a(1'b1, 1'b1, 10'h101, 2'b01);
    drive_b(1'b1, 1'b1, 10'h102, 2'b10);
    step;
    checks++;
    if (coll !== 1'b0) begin failures++; $display("FAIL coll_diff_addr got=%b required=0", coll); end
    drive_a(1'b1, 1'b0, 10'h101, '0);
    drive_b(1'b1, 1'b0, 10'h102, '0);
    step;
    checks++;
    if (a_dout !== 2'b01 || b_dout !== 2'b10 || coll !== 1'b0) begin
      failures++; $display("FAIL coll_diff_data a=%b b=%b coll=%b required=01 10 0", a_dout, b_dout, coll);
    end
    idle;
    step;
  endtask

  task automatic test_blocked;
    // b_dout holds 2'b10 from the previous read of 0x102
    clr_req = 1'b1;
    step;
    clr_req = 1'b0;
    drive_a(1'b1, 1'b1, 10'h002, 2'b00);
    drive_b(1'b1, 1'b0, 10'h005, '0);
    step;
    checks++;
    if (busy !== 1'b1 || b_valid !== 1'b0 || a_valid !== 1'b0 || b_dout !== 2'b10) begin
      failures++;
      $display("FAIL blocked_read busy=%b b_valid=%b a_valid=%b b_dout=%b required=1 0 0 10",
               busy, b_valid, a_valid, b_dout);
    end
    drive_a(1'b1, 1'b1, 10'h003, 2'b00);
    drive_b(1'b1, 1'b1, 10'h003, 2'b01);
    step;
    checks++;
    if (coll !== 1'b0) begin failures++; $display("FAIL blocked_coll got=%b required=0", coll); end
    idle;
    wait_idle("blocked_fill");
    step;
    drive_a(1'b1, 1'b0, 10'h002, '0);
    drive_b(1'b1, 1'b0, 10'h003, '0);
    step;
    checks++;
    if (a_dout !== FILL || b_dout !== FILL) begin
      failures++; $display("FAIL blocked_no_write a=%b b=%b required=%b", a_dout, b_dout, FILL);
    end
    idle;
    step;
  endtask

  task automatic test_reset_midfill;
    int cnt, done_at;
    clr_req = 1'b1;
    step;
    clr_req = 1'b0;
    drive_a(1'b1, 1'b0, 10'h101, '0);
    repeat (3) step;
    idle;
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, clr_done, coll, a_valid, b_valid, a_dout, b_dout} !== '0) begin
      failures++;
      $display("FAIL midfill_reset_outputs got=%b required=0",
               {busy, clr_done, coll, a_valid, b_valid, a_dout, b_dout});
    end
    #2;
    rstn = 1'b1;
    step;
`ifdef WVFM_LUT_AUTOCLR_EN
    cnt = 0; done_at = -1;
    for (int i = 0; i < HALF + 4; i++) begin
      if (busy) cnt++;
      if (clr_done) done_at = cnt;
      step;
    end
    checks++;
    if (cnt != HALF || done_at != HALF) begin
      failures++; $display("FAIL midfill_autoclr busy_cycles=%0d done_at=%0d required=%0d", cnt, done_at, HALF);
    end
`else
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midfill_idle_busy got=%b required=0", busy); end
    step;
    checks++;
    if (busy !== 1'b0 || clr_done !== 1'b0) begin
      failures++; $display("FAIL midfill_stays_idle busy=%b clr_done=%b required=0 0", busy, clr_done);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_fill;
    test_rw;
    test_forward;
    test_collision;
    test_blocked;
    test_reset_midfill;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
